// File: rtl/conv11_sched_pkg.sv
// conv1x1 output scheduler: shared types and constants.
// State encoding and channel-index width helper.
package conv11_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } sched_state_t;

    localparam int NUM_CH_DEF = 4;
    localparam int CH_W       = $clog2(NUM_CH_DEF);

endpackage

// File: rtl/conv11_pending_tracker.sv
// Per-channel unread-result flags for the conv1x1 output buffers.
// Flags a lost word when a full buffer is rewritten without a read.
module conv11_pending_tracker
    import conv11_sched_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] buf_wr,
    input  logic [NUM_CH-1:0] buf_rd_en,
    input  logic              clr_overrun,
    output logic [NUM_CH-1:0] pending,
    output logic              overrun
);

    logic [NUM_CH-1:0] lost;

    assign lost = buf_wr & pending & ~buf_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            // A same-cycle write keeps the buffer full after a read.
            pending <= buf_wr | (pending & ~buf_rd_en);
            if (|lost)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/conv11_output_sched.sv
// Drains per-channel conv1x1 output buffers in channel order
// onto a valid/ready stream, counting pixels per frame.
module conv11_output_sched
    import conv11_sched_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int OUT_WIDTH     = 8,
    parameter int PIX_PER_FRAME = 784,
    parameter int CNT_W         = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           buf_wr,
    output logic [NUM_CH-1:0]           buf_rd_en,
    input  logic [NUM_CH-1:0]           buf_out_valid,
    input  logic [NUM_CH*OUT_WIDTH-1:0] buf_out_data,
    output logic                        m_valid,
    output logic [OUT_WIDTH-1:0]        m_data,
    output logic [$clog2(NUM_CH)-1:0]   m_ch,
    input  logic                        m_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam int CW = $clog2(NUM_CH);

    sched_state_t         state_q, state_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [CNT_W-1:0]     pix_q, pix_d;
    logic                 mv_q, mv_d;
    logic [OUT_WIDTH-1:0] md_q, md_d;
    logic [CW-1:0]        mc_q, mc_d;

    logic [NUM_CH-1:0]    pending;
    logic                 start_ok;
    logic                 sel_pend;
    logic                 sel_valid;
    logic [OUT_WIDTH-1:0] sel_data;
    logic                 last_ch;
    logic                 last_pix;

    assign start_ok = start && (state_q == S_IDLE);
    assign last_ch  = (ch_q == CW'(NUM_CH - 1));
    assign last_pix = (pix_q == CNT_W'(PIX_PER_FRAME - 1));

    conv11_pending_tracker #(
        .NUM_CH(NUM_CH)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .buf_wr     (buf_wr),
        .buf_rd_en  (buf_rd_en),
        .clr_overrun(start_ok),
        .pending    (pending),
        .overrun    (overrun)
    );

    // Mux the current channel's flag and buffer output.
    always_comb begin
        sel_pend  = 1'b0;
        sel_valid = 1'b0;
        sel_data  = '0;
        buf_rd_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CW'(c)) begin
                sel_pend     = pending[c];
                sel_valid    = buf_out_valid[c];
                sel_data     = buf_out_data[c*OUT_WIDTH +: OUT_WIDTH];
                buf_rd_en[c] = (state_q == S_ISSUE);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        mv_d    = mv_q;
        md_d    = md_q;
        mc_d    = mc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_d    = '0;
                    pix_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_pend)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (sel_valid) begin
                    md_d    = sel_data;
                    mc_d    = ch_q;
                    mv_d    = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (m_ready) begin
                    mv_d = 1'b0;
                    if (!last_ch) begin
                        ch_d    = ch_q + CW'(1);
                        state_d = S_WAIT;
                    end else begin
                        ch_d = '0;
                        if (last_pix) begin
                            state_d = S_DONE;
                        end else begin
                            pix_d   = pix_q + CNT_W'(1);
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            pix_q   <= '0;
            mv_q    <= 1'b0;
            md_q    <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            mc_q    <= mc_d;
        end
    end

    assign m_valid    = mv_q;
    assign m_data     = md_q;
    assign m_ch       = mc_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_conv11_output_sched.sv
// Directed bench for conv11_output_sched with a model of four
// single-entry output buffers (one-cycle registered read).
module tb_conv11_output_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  buf_wr;
    logic [3:0]  buf_rd_en;
    logic [3:0]  buf_out_valid;
    logic [31:0] buf_out_data;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  m_ch;
    logic        m_ready;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    logic [7:0]  wd  [4];
    logic [7:0]  mem [4];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  bdata[$];
    logic [1:0]  bch[$];
    int          last_acc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        busy_at_done = 1'b1;
    int          multi_rd = 0;
    logic [3:0]  rd_seen;

    always #5 clk = ~clk;

    conv11_output_sched #(
        .NUM_CH       (4),
        .OUT_WIDTH    (8),
        .PIX_PER_FRAME(2),
        .CNT_W        (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .buf_wr       (buf_wr),
        .buf_rd_en    (buf_rd_en),
        .buf_out_valid(buf_out_valid),
        .buf_out_data (buf_out_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ch         (m_ch),
        .m_ready      (m_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            buf_out_valid <= '0;
            buf_out_data  <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                buf_out_valid[c] <= buf_rd_en[c];
                if (buf_rd_en[c])
                    buf_out_data[c*8 +: 8] <= mem[c];
                if (buf_wr[c])
                    mem[c] <= wd[c];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            bdata.push_back(m_data);
            bch.push_back(m_ch);
            last_acc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if ($countones(buf_rd_en) > 1)
            multi_rd++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] m, input logic [31:0] d);
        for (int c = 0; c < 4; c++)
            wd[c] = d[c*8 +: 8];
        buf_wr = m;
        tick();
        buf_wr = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k = 0;
        while (bdata.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, bdata.size(), n);
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_cnt < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, done_cnt, n);
    endtask

    task automatic wait_mvalid(input string tag);
        int k = 0;
        while (!m_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(tag, m_valid, 1);
    endtask

    task automatic clear_q();
        bdata.delete();
        bch.delete();
    endtask

    initial begin
        int d0;
        int k;
        rst     = 1'b1;
        start   = 1'b0;
        buf_wr  = '0;
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++)
            wd[c] = '0;
        repeat (3) tick();
        check("rst_mvalid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovr", overrun, 0);
        check("rst_rden", buf_rd_en, 0);
        check("rst_mdata", m_data, 0);
        check("rst_mch", m_ch, 0);
        rst = 1'b0;
        tick();

        // all channels written together, two pixels
        m_ready = 1'b1;
        clear_q();
        pulse_start();
        check("t1_busy", busy, 1);
        wr(4'hF, 32'hA3A2A1A0);
        wait_beats(4, "t1_b4");
        wr(4'hF, 32'hB3B2B1B0);
        wait_beats(8, "t1_b8");
        wait_done(1, "t1_done");
        for (int i = 0; i < 8; i++) begin
            check("t1_ch", bch[i], i % 4);
            check("t1_data", bdata[i],
                  (i < 4 ? 32'hA0 : 32'hB0) + (i % 4));
        end
        check("t1_done_lat", done_cyc - last_acc, 1);
        check("t1_busy_done", busy_at_done, 0);
        check("t1_ovr", overrun, 0);

        // out-of-order writes, in-order output
        clear_q();
        pulse_start();
        wr(4'h4, 32'h0022_0000);
        wr(4'h1, 32'h0000_0000);
        wr(4'h8, 32'h3300_0000);
        wr(4'h2, 32'h0000_1100);
        wait_beats(4, "t2_b4");
        for (int i = 0; i < 4; i++) begin
            check("t2_ch", bch[i], i);
            check("t2_data", bdata[i], 32'h11 * i);
        end
        wr(4'hF, 32'h43424140);
        wait_beats(8, "t2_b8");
        wait_done(2, "t2_done");

        // backpressure holds the beat stable
        clear_q();
        m_ready = 1'b0;
        pulse_start();
        wr(4'hF, 32'h53525150);
        wait_mvalid("t3_mv");
        rd_seen = '0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_v", m_valid, 1);
            check("t3_hold_d", m_data, 32'h50);
            check("t3_hold_c", m_ch, 0);
            rd_seen = rd_seen | buf_rd_en;
            @(negedge clk);
        end
        check("t3_no_rd", rd_seen, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_beats(4, "t3_b4");
        check("t3_d0", bdata[0], 32'h50);
        check("t3_d3", bdata[3], 32'h53);
        wr(4'hF, 32'h57565554);
        wait_beats(8, "t3_b8");
        wait_done(3, "t3_done");

        // overrun from a double write, cleared by start
        clear_q();
        wr(4'h2, 32'h0000_6100);
        wr(4'h2, 32'h0000_7100);
        check("t4_ovr_set", overrun, 1);
        repeat (3) tick();
        check("t4_ovr_stk", overrun, 1);
        pulse_start();
        check("t4_ovr_clr", overrun, 0);
        wr(4'hD, 32'h6362_0060);
        wait_beats(4, "t4_b4");
        check("t4_ch1", bch[1], 1);
        check("t4_d1", bdata[1], 32'h71);
        wr(4'hF, 32'h67666564);
        wait_beats(8, "t4_b8");
        wait_done(4, "t4_done");

        // write into ch0 on the same cycle it is read
        clear_q();
        pulse_start();
        wr(4'hF, 32'h83828180);
        k = 0;
        while (!buf_rd_en[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t5_rd0", buf_rd_en, 4'h1);
        wr(4'h1, 32'h0000_0090);
        check("t5_ovr", overrun, 0);
        wait_beats(4, "t5_b4");
        wr(4'hE, 32'h9392_9100);
        wait_beats(8, "t5_b8");
        check("t5_d0", bdata[0], 32'h80);
        check("t5_d4", bdata[4], 32'h90);
        check("t5_c4", bch[4], 0);
        check("t5_d7", bdata[7], 32'h93);
        wait_done(5, "t5_done");
        check("t5_ovr_end", overrun, 0);

        // reset while a beat waits in SEND
        clear_q();
        m_ready = 1'b0;
        pulse_start();
        wr(4'hF, 32'hC3C2C1C0);
        wait_mvalid("t6_mv");
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("t6_mvalid", m_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_fdone", frame_done, 0);
        rst = 1'b0;
        repeat (4) tick();
        check("t6_no_done", done_cnt, d0);
        clear_q();
        m_ready = 1'b1;
        pulse_start();
        wr(4'hF, 32'hD3D2D1D0);
        wait_beats(1, "t6_b1");
        check("t6_ch0", bch[0], 0);
        check("t6_d0", bdata[0], 32'hD0);
        wait_beats(4, "t6_b4");
        wr(4'hF, 32'hE3E2E1E0);
        wait_beats(8, "t6_b8");
        check("t6_d7", bdata[7], 32'hE3);
        wait_done(d0 + 1, "t6_done");

        check("rd_onehot", multi_rd, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
